trdb_ctrl_regs: RTL and testbench

APB-programmable control/status register block for the trace encoder. It holds the packet-emitter option fields and runs a trace-session FSM (idle/armed/tracing/draining) driven by software or by trigger-unit on/off requests. It exposes session counters and gates the encoder clock. It sits between the system APB bus and the encoder core, feeding the filter, packet emitter and clock gate.

---
 rtl/trdb_pkg.sv | 58 +++++
 rtl/pulp_clock_gating.sv | 19 +
 rtl/trdb_apb_regif.sv | 106 ++++++++++
 rtl/trdb_ctrl_regs.sv | 166 ++++++++++++++++
 tb/tb_trdb_ctrl_regs.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trdb_pkg.sv
// Shared types and register layout for the trace debug control block.
package trdb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    TRACING  = 2'd2,
    DRAINING = 2'd3
  } trdb_sess_e;

  typedef enum logic [1:0] {
    DELTA_ADDRESS = 2'd0,
    FULL_ADDRESS  = 2'd1
  } ioptions_e;

  // Word index of each register (byte address bits [4:2])
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_TRACE_CYC = 3'd2;
  localparam logic [2:0] REG_START_CNT = 3'd3;
  localparam logic [2:0] REG_ID        = 3'd4;

  localparam int unsigned CTRL_ACTIVATED = 0;
  localparam int unsigned CTRL_START     = 1;
  localparam int unsigned CTRL_STOP      = 2;
  localparam int unsigned CTRL_NOCONTEXT = 3;
  localparam int unsigned CTRL_NOTIME    = 4;
  localparam int unsigned CTRL_FULL_ADDR = 5;
  localparam int unsigned CTRL_IMPL_RET  = 6;
  localparam int unsigned CTRL_TRIG_EN   = 7;

  localparam int unsigned STATUS_STATE    = 0;
  localparam int unsigned STATUS_ENC_IDLE = 2;
  localparam int unsigned STATUS_DRAIN_TO = 3;

  typedef struct packed {
    logic trig_en;
    logic implicit_return;
    logic full_address;
    logic notime;
    logic nocontext;
    logic activated;
  } trdb_ctrl_t;

  // Start/stop are write-one pulses and always read back as zero.
  function automatic logic [31:0] ctrl_to_word(trdb_ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_ACTIVATED] = c.activated;
    w[CTRL_NOCONTEXT] = c.nocontext;
    w[CTRL_NOTIME]    = c.notime;
    w[CTRL_FULL_ADDR] = c.full_address;
    w[CTRL_IMPL_RET]  = c.implicit_return;
    w[CTRL_TRIG_EN]   = c.trig_en;
    return w;
  endfunction

endpackage

// File: rtl/pulp_clock_gating.sv
// Latch-based clock gate: enable captured while the clock is low.
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic clk_en;

  always_latch begin
    if (!clk_i) begin
      clk_en <= en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/trdb_apb_regif.sv
// APB slave front end: address decode, error response, read mux and CTRL storage.
module trdb_apb_regif
  import trdb_pkg::*;
#(
  parameter int unsigned APB_AW   = 12,
  parameter logic [31:0] ID_VALUE = 32'h7E0C_0001
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [APB_AW-1:0] paddr_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o,
  input  logic              opt_lock_i,
  input  trdb_sess_e        state_i,
  input  logic              encoder_idle_i,
  input  logic              drain_to_i,
  input  logic [31:0]       trace_cyc_i,
  input  logic [31:0]       start_cnt_i,
  output trdb_ctrl_t        ctrl_o,
  output logic              start_o,
  output logic              stop_o,
  output logic              clr_cyc_o,
  output logic              clr_start_o
);

  logic        access, wr, rd;
  logic [2:0]  reg_idx;
  logic        wr_ok, rd_ok, wr_ctrl;
  logic [31:0] rdata;
  trdb_ctrl_t  ctrl_q;
  logic        unused_bits;

  assign access  = psel_i & penable_i;
  assign wr      = access & pwrite_i;
  assign rd      = access & ~pwrite_i;
  assign reg_idx = paddr_i[4:2];

  assign unused_bits = ^{paddr_i[APB_AW-1:5], paddr_i[1:0], pwdata_i[31:8]};

  always_comb begin
    wr_ok = 1'b0;
    rd_ok = 1'b0;
    rdata = '0;
    case (reg_idx)
      REG_CTRL: begin
        wr_ok = 1'b1;
        rd_ok = 1'b1;
        rdata = ctrl_to_word(ctrl_q);
      end
      REG_STATUS: begin
        rd_ok = 1'b1;
        rdata[STATUS_STATE +: 2]  = state_i;
        rdata[STATUS_ENC_IDLE]    = encoder_idle_i;
        rdata[STATUS_DRAIN_TO]    = drain_to_i;
      end
      REG_TRACE_CYC: begin
        wr_ok = 1'b1;
        rd_ok = 1'b1;
        rdata = trace_cyc_i;
      end
      REG_START_CNT: begin
        wr_ok = 1'b1;
        rd_ok = 1'b1;
        rdata = start_cnt_i;
      end
      REG_ID: begin
        rd_ok = 1'b1;
        rdata = ID_VALUE;
      end
      default: ;
    endcase
  end

  assign prdata_o  = rd ? rdata : '0;
  assign pslverr_o = (wr & ~wr_ok) | (rd & ~rd_ok);

  assign wr_ctrl     = wr & (reg_idx == REG_CTRL);
  assign start_o     = wr_ctrl & pwdata_i[CTRL_START];
  assign stop_o      = wr_ctrl & pwdata_i[CTRL_STOP];
  assign clr_cyc_o   = wr & (reg_idx == REG_TRACE_CYC);
  assign clr_start_o = wr & (reg_idx == REG_START_CNT);

  // Option fields freeze mid-session; activated and trig_en stay writable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '{trig_en: 1'b1, implicit_return: 1'b0, full_address: 1'b0,
                  notime: 1'b1, nocontext: 1'b1, activated: 1'b0};
    end else if (wr_ctrl) begin
      ctrl_q.activated <= pwdata_i[CTRL_ACTIVATED];
      ctrl_q.trig_en   <= pwdata_i[CTRL_TRIG_EN];
      if (!opt_lock_i) begin
        ctrl_q.nocontext       <= pwdata_i[CTRL_NOCONTEXT];
        ctrl_q.notime          <= pwdata_i[CTRL_NOTIME];
        ctrl_q.full_address    <= pwdata_i[CTRL_FULL_ADDR];
        ctrl_q.implicit_return <= pwdata_i[CTRL_IMPL_RET];
      end
    end
  end

  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/trdb_ctrl_regs.sv
// Trace encoder control/status block: session FSM, counters and encoder clock gate.
module trdb_ctrl_regs
  import trdb_pkg::*;
#(
  parameter int unsigned APB_AW   = 12,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DRAIN_TO = 256,
  parameter logic [31:0] ID_VALUE = 32'h7E0C_0001
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [APB_AW-1:0] paddr_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic              trace_req_on_i,
  input  logic              trace_req_off_i,
  input  logic              encoder_idle_i,
  input  logic              testmode_i,
  output logic              trace_enable_o,
  output logic              trace_activated_o,
  output logic              nocontext_o,
  output logic              notime_o,
  output logic              full_address_o,
  output logic              implicit_return_o,
  output logic              delta_address_o,
  output logic              encoder_mode_o,
  output ioptions_e         configuration_o,
  output logic              clk_gated_o
);

  localparam int unsigned DCW = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TO - 1);

  trdb_sess_e       state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             drain_to_q, drain_to_d;
  logic [CNT_W-1:0] trace_cyc_q, start_cnt_q;
  logic             trace_enable_q;
  logic             arm_to_trace;
  trdb_ctrl_t       ctrl;
  logic             start, stop, clr_cyc, clr_start;
  logic             on_req, off_req, opt_lock, clk_en;

  trdb_apb_regif #(
    .APB_AW   (APB_AW),
    .ID_VALUE (ID_VALUE)
  ) i_regif (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .paddr_i        (paddr_i),
    .psel_i         (psel_i),
    .penable_i      (penable_i),
    .pwrite_i       (pwrite_i),
    .pwdata_i       (pwdata_i),
    .prdata_o       (prdata_o),
    .pslverr_o      (pslverr_o),
    .opt_lock_i     (opt_lock),
    .state_i        (state_q),
    .encoder_idle_i (encoder_idle_i),
    .drain_to_i     (drain_to_q),
    .trace_cyc_i    (32'(trace_cyc_q)),
    .start_cnt_i    (32'(start_cnt_q)),
    .ctrl_o         (ctrl),
    .start_o        (start),
    .stop_o         (stop),
    .clr_cyc_o      (clr_cyc),
    .clr_start_o    (clr_start)
  );

  assign opt_lock = (state_q == TRACING) || (state_q == DRAINING);
  assign on_req   = start | (ctrl.trig_en & trace_req_on_i);
  assign off_req  = stop | (ctrl.trig_en & trace_req_off_i) | ~ctrl.activated;

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = '0;
    drain_to_d   = drain_to_q;
    arm_to_trace = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl.activated) state_d = ARMED;
      end
      ARMED: begin
        if (!ctrl.activated) begin
          state_d = IDLE;
        end else if (on_req && !off_req) begin
          state_d      = TRACING;
          arm_to_trace = 1'b1;
        end
      end
      TRACING: begin
        if (off_req) state_d = DRAINING;
      end
      DRAINING: begin
        if (encoder_idle_i) begin
          state_d = ctrl.activated ? ARMED : IDLE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d    = ctrl.activated ? ARMED : IDLE;
          drain_to_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      drain_cnt_q    <= '0;
      drain_to_q     <= 1'b0;
      trace_enable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      drain_to_q     <= drain_to_d;
      trace_enable_q <= (state_d == TRACING);
    end
  end

  // Saturating counters; a software clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trace_cyc_q <= '0;
      start_cnt_q <= '0;
    end else begin
      if (clr_cyc) begin
        trace_cyc_q <= '0;
      end else if ((state_q == TRACING) && (trace_cyc_q != '1)) begin
        trace_cyc_q <= trace_cyc_q + CNT_W'(1);
      end
      if (clr_start) begin
        start_cnt_q <= '0;
      end else if (arm_to_trace && (start_cnt_q != '1)) begin
        start_cnt_q <= start_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pready_o          = 1'b1;
  assign trace_enable_o    = trace_enable_q;
  assign trace_activated_o = ctrl.activated;
  assign nocontext_o       = ctrl.nocontext;
  assign notime_o          = ctrl.notime;
  assign full_address_o    = ctrl.full_address;
  assign implicit_return_o = ctrl.implicit_return;
  assign delta_address_o   = ~ctrl.full_address;
  assign encoder_mode_o    = 1'b0;
  assign configuration_o   = ctrl.full_address ? FULL_ADDRESS : DELTA_ADDRESS;

  assign clk_en = ctrl.activated | (state_q != IDLE);

  pulp_clock_gating i_clk_gate (
    .clk_i     (clk_i),
    .en_i      (clk_en),
    .test_en_i (testmode_i),
    .clk_o     (clk_gated_o)
  );

endmodule

// File: tb/tb_trdb_ctrl_regs.sv
// Scoreboard bench for trdb_ctrl_regs: reference model predicts every APB response.
module tb_trdb_ctrl_regs;
  import trdb_pkg::*;

  localparam int unsigned TB_CNT_W    = 8;
  localparam int          TB_DRAIN_TO = 4;
  localparam logic [31:0] TB_ID       = 32'h7E0C_0001;
  localparam int          SAT         = (1 << TB_CNT_W) - 1;
  localparam int M_IDLE = 0, M_ARMED = 1, M_TRACING = 2, M_DRAINING = 3;

  logic        clk, rst_n;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        req_on, req_off, enc_idle, testmode;
  logic        trace_enable_o, trace_activated_o, nocontext_o, notime_o;
  logic        full_address_o, implicit_return_o, delta_address_o, encoder_mode_o;
  ioptions_e   configuration_o;
  logic        clk_gated;

  trdb_ctrl_regs #(
    .APB_AW   (12),
    .CNT_W    (TB_CNT_W),
    .DRAIN_TO (TB_DRAIN_TO),
    .ID_VALUE (TB_ID)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n),
    .paddr_i (paddr), .psel_i (psel), .penable_i (penable), .pwrite_i (pwrite),
    .pwdata_i (pwdata), .prdata_o (prdata), .pready_o (pready), .pslverr_o (pslverr),
    .trace_req_on_i (req_on), .trace_req_off_i (req_off),
    .encoder_idle_i (enc_idle), .testmode_i (testmode),
    .trace_enable_o (trace_enable_o), .trace_activated_o (trace_activated_o),
    .nocontext_o (nocontext_o), .notime_o (notime_o), .full_address_o (full_address_o),
    .implicit_return_o (implicit_return_o), .delta_address_o (delta_address_o),
    .encoder_mode_o (encoder_mode_o), .configuration_o (configuration_o),
    .clk_gated_o (clk_gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_cyc, m_starts, m_dcycles;
  bit m_act, m_trig, m_noctx, m_notime, m_full, m_impl, m_dto;

  task automatic model_reset();
    m_state = M_IDLE; m_cyc = 0; m_starts = 0; m_dcycles = 0;
    m_act = 0; m_trig = 1; m_noctx = 1; m_notime = 1; m_full = 0; m_impl = 0; m_dto = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit wr, on_c, off_c, leave;
    int idx, ns;
    logic [2:0] a;
    if (!rst_n) begin model_reset(); return; end
    a     = paddr[4:2];
    idx   = int'(a);
    wr    = psel && penable && pwrite;
    on_c  = (wr && idx == 0 && pwdata[1]) || (m_trig && req_on);
    off_c = (wr && idx == 0 && pwdata[2]) || (m_trig && req_off) || !m_act;
    ns = m_state; leave = 0;
    case (m_state)
      M_IDLE:    if (m_act) ns = M_ARMED;
      M_ARMED:   if (!m_act) ns = M_IDLE; else if (on_c && !off_c) ns = M_TRACING;
      M_TRACING: if (off_c) ns = M_DRAINING;
      default: begin
        if (enc_idle) leave = 1;
        else if (m_dcycles + 1 == TB_DRAIN_TO) begin leave = 1; m_dto = 1; end
        if (leave) ns = m_act ? M_ARMED : M_IDLE;
      end
    endcase
    if (wr && idx == 2) m_cyc = 0;
    else if (m_state == M_TRACING && m_cyc < SAT) m_cyc++;
    if (wr && idx == 3) m_starts = 0;
    else if (m_state == M_ARMED && ns == M_TRACING && m_starts < SAT) m_starts++;
    if (wr && idx == 0) begin
      m_act  = pwdata[0];
      m_trig = pwdata[7];
      if (m_state == M_IDLE || m_state == M_ARMED) begin
        m_noctx = pwdata[3]; m_notime = pwdata[4]; m_full = pwdata[5]; m_impl = pwdata[6];
      end
    end
    m_dcycles = (m_state == M_DRAINING && ns == M_DRAINING) ? m_dcycles + 1 : 0;
    m_state = ns;
  endtask

  function automatic logic [9:0] model_outs();
    return {m_state == M_TRACING, m_act, m_noctx, m_notime, m_full, m_impl,
            !m_full, 1'b0, m_full, 1'b1};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    bit          err;
    logic [9:0]  outs;
    string       name;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (psel && penable) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_err"}, {31'd0, pslverr}, {31'd0, e.err});
        if (e.is_rd) check({e.name, "_rdata"}, prdata, e.rdata);
        check({e.name, "_outs"},
              {22'd0, trace_enable_o, trace_activated_o, nocontext_o, notime_o,
               full_address_o, implicit_return_o, delta_address_o, encoder_mode_o,
               configuration_o == FULL_ADDRESS, pready},
              {22'd0, e.outs});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                     input string name);
    exp_t e;
    logic [2:0] a;
    int idx;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    tick();
    penable = 1;
    a = addr[4:2];
    idx = int'(a);
    e.is_rd = !wr; e.name = name; e.outs = model_outs(); e.rdata = '0;
    if (wr) e.err = !(idx == 0 || idx == 2 || idx == 3);
    else begin
      e.err = (idx > 4);
      case (idx)
        0: e.rdata = {24'd0, m_trig, m_impl, m_full, m_notime, m_noctx, 3'b000} | {31'd0, m_act};
        1: e.rdata = {28'd0, m_dto, enc_idle, 2'(m_state)};
        2: e.rdata = 32'(m_cyc);
        3: e.rdata = 32'(m_starts);
        4: e.rdata = TB_ID;
        default: e.rdata = '0;
      endcase
    end
    sb.push_back(e);
    tick();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  int gcnt = 0;
  always @(posedge clk_gated) gcnt++;

  task automatic gate_check(input string name, input int exp);
    int g0;
    g0 = gcnt;
    repeat (10) tick();
    check(name, 32'(gcnt - g0), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    req_on = 0; req_off = 0; enc_idle = 1; testmode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_trace_en", {31'd0, trace_enable_o}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    rst_n = 1;

    // reset values and decode
    apb(0, 12'h000, 0, "rd_ctrl_rst");
    apb(0, 12'h004, 0, "rd_status_rst");
    apb(0, 12'h010, 0, "rd_id");
    apb(0, 12'h008, 0, "rd_cyc_rst");
    apb(0, 12'h014, 0, "rd_unmapped");
    gate_check("gate_off_idle", 0);
    testmode = 1;
    gate_check("gate_testmode", 10);
    testmode = 0;

    // software start path, then trigger-driven session with clean drain
    apb(1, 12'h000, 32'h83, "wr_ctrl_act_start");
    tick();
    apb(0, 12'h004, 0, "rd_status_armed");
    gate_check("gate_armed", 10);
    req_on = 1; tick(); req_on = 0;
    apb(0, 12'h004, 0, "rd_status_tracing");
    apb(0, 12'h00C, 0, "rd_start_cnt");
    apb(1, 12'h008, 32'hFFFF, "wr_clr_cyc");
    repeat (10) tick();
    apb(0, 12'h008, 0, "rd_cyc_10");
    enc_idle = 0; req_off = 1; tick(); req_off = 0;
    tick();
    apb(0, 12'h004, 0, "rd_status_draining");
    enc_idle = 1; tick();
    apb(0, 12'h004, 0, "rd_status_back_armed");

    // forced drain exit
    req_on = 1; tick(); req_on = 0;
    repeat (3) tick();
    enc_idle = 0; req_off = 1; tick(); req_off = 0;
    repeat (6) tick();
    apb(0, 12'h004, 0, "rd_status_drain_to");
    enc_idle = 1;

    // option lock while tracing, unlocked while armed
    req_on = 1; tick(); req_on = 0;
    apb(1, 12'h000, 32'hA1, "wr_opts_locked");
    apb(0, 12'h000, 0, "rd_ctrl_locked");
    apb(1, 12'h000, 32'h85, "wr_ctrl_stop");
    tick(); tick();
    apb(1, 12'h000, 32'hA1, "wr_opts_armed");
    apb(0, 12'h000, 0, "rd_ctrl_armed");

    // error responses and counter clear
    apb(1, 12'h014, 32'h1, "wr_unmapped");
    apb(1, 12'h004, 32'hF, "wr_status");
    apb(1, 12'h010, 32'h0, "wr_id");
    apb(1, 12'h00C, 32'h0, "wr_clr_start");
    apb(0, 12'h00C, 0, "rd_start_cleared");
    apb(0, 12'h020, 0, "rd_ctrl_alias");

    // counter saturation
    req_on = 1; tick(); req_on = 0;
    repeat (300) tick();
    apb(0, 12'h008, 0, "rd_cyc_sat");

    // reset mid-session
    #3;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_mid_trace_en", {31'd0, trace_enable_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    apb(0, 12'h004, 0, "rd_status_after_rst");
    apb(0, 12'h008, 0, "rd_cyc_after_rst");

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      logic [31:0] d;
      r = int'($urandom_range(0, 9));
      req_on   = ($urandom_range(0, 5) == 0);
      req_off  = ($urandom_range(0, 7) == 0);
      enc_idle = ($urandom_range(0, 3) != 0);
      if (r < 4) begin
        d = $urandom;
        if ($urandom_range(0, 4) != 0) d[0] = 1'b1;
        apb(bit'($urandom_range(0, 1)), {7'd0, 3'($urandom_range(0, 7)), 2'b00}, d, "rand");
      end else begin
        tick();
      end
    end
    req_on = 0; req_off = 0;
    tick(); tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
